// File: rtl/gray_window_3x3.sv
// Streaming 3x3 neighbourhood generator: raster pixels in, one padded window per pixel out.
// Optional build macro WINDOW_REPLICATE_EN selects edge-clamp padding instead of zero padding.
module gray_window_3x3 #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  gray_i,
  input  logic        done_i,
  output logic [71:0] window_o,
  output logic        done_o,
  output logic        busy_o
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

  state_t        state, state_next;
  logic [CW-1:0] in_col, out_col;
  logic [RW-1:0] in_row, out_row;

  logic [7:0] lb1 [WIDTH];   // row r-1
  logic [7:0] lb2 [WIDTH];   // row r-2
  // Two stored columns per window row; the third (rightmost) column is the live
  // column formed from the line-buffer reads and the incoming pixel.
  logic [7:0] sr  [3][2];
  logic [7:0] new_col [3];
  logic [7:0] t [3][3];
  logic [71:0] win;

  logic accept, step, emit;
  logic pad_top, pad_bot, pad_left, pad_right;

  assign busy_o = (state == FLUSH);
  assign accept = done_i && (state != FLUSH);
  assign step   = accept || (state == FLUSH);

  assign new_col[0] = lb2[in_col];
  assign new_col[1] = lb1[in_col];
  assign new_col[2] = gray_i;

  assign pad_top   = (out_row == '0);
  assign pad_bot   = (out_row == ROW_LAST);
  assign pad_left  = (out_col == '0);
  assign pad_right = (out_col == COL_LAST);

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    emit       = 1'b0;
    case (state)
      FILL: begin
        if (accept && in_row == ROW_ONE && in_col == COL_ONE) begin
          state_next = STREAM;
          emit       = 1'b1;
        end
      end
      STREAM: begin
        if (accept) begin
          emit = 1'b1;
          if (in_row == ROW_LAST && in_col == COL_LAST) state_next = FLUSH;
        end
      end
      FLUSH: begin
        emit = 1'b1;
        if (out_row == ROW_LAST && out_col == COL_LAST) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // Window centred on the previous stored column; padding is driven purely by out_row/out_col.
  always_comb begin
    win = '0;
    for (int r = 0; r < 3; r++) begin
      t[r][0] = sr[r][0];
      t[r][1] = sr[r][1];
      t[r][2] = new_col[r];
    end
`ifdef WINDOW_REPLICATE_EN
    for (int r = 0; r < 3; r++) begin
      if (pad_left)  t[r][0] = t[r][1];
      if (pad_right) t[r][2] = t[r][1];
    end
    for (int c = 0; c < 3; c++) begin
      if (pad_top) t[0][c] = t[1][c];
      if (pad_bot) t[2][c] = t[1][c];
    end
`else
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if ((r == 0 && pad_top) || (r == 2 && pad_bot) ||
            (c == 0 && pad_left) || (c == 2 && pad_right))
          t[r][c] = '0;
      end
    end
`endif
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win[(3*r+c)*8 +: 8] = t[r][c];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      in_col   <= '0;
      in_row   <= '0;
      out_col  <= '0;
      out_row  <= '0;
      window_o <= '0;
      done_o   <= 1'b0;
    end else begin
      state  <= state_next;
      done_o <= emit;
      if (emit) begin
        window_o <= win;
        if (out_col == COL_LAST) begin
          out_col <= '0;
          out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
      if (accept) begin
        if (in_col == COL_LAST) begin
          in_col <= '0;
          in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end else if (state == FLUSH) begin
        // Flush walks the line-buffer read address over one more row, then parks at 0.
        if (state_next == FILL || in_col == COL_LAST) in_col <= '0;
        else                                          in_col <= in_col + 1'b1;
      end
    end
  end

  // NOTE: line buffers and column registers are not reset; padding hides any stale content.
  always_ff @(posedge clk) begin
    if (step) begin
      for (int r = 0; r < 3; r++) begin
        sr[r][0] <= sr[r][1];
        sr[r][1] <= new_col[r];
      end
    end
    if (accept) begin
      lb2[in_col] <= lb1[in_col];
      lb1[in_col] <= gray_i;
    end
  end

endmodule
